ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one `single_port_RAM` instance between two requesters: port A (weight/feature loader) and port B (convolution engine). Each port uses a req/gnt handshake. The arbiter issues at most one RAM command per cycle through registered RAM-side outputs. Read data is routed back to the originating port with a fixed latency, and out-of-range addresses are trapped before they reach the RAM.

## Interface
Parameters:
- `memoryDepth`, 27, number of valid RAM words; legal addresses are 0..memoryDepth-1.
- `addressBitWidth`, 16, address width on all ports.
- `dataBitWidth`, 16, data width; data is signed.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_a` / `req_b`  in  1  request; must be held with its command until `gnt_x` is sampled high.
- `we_a` / `we_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  addressBitWidth  word address.
- `wdata_a` / `wdata_b`  in  dataBitWidth signed  write data.
- `gnt_a` / `gnt_b`  out  1  combinational grant; the command is accepted on the rising edge where req and gnt are both high.
- `rvalid_a` / `rvalid_b`  out  1  one-cycle pulse; `rdata_x` is valid during it.
- `rdata_a` / `rdata_b`  out  dataBitWidth signed  read data.
- `err_a` / `err_b`  out  1  one-cycle pulse that accompanies `rvalid_x`, or a write ack, when the address was out of range.
- `ram_read_enable`, `ram_write_enable`  out  1  registered RAM enables.
- `ram_address`  out  addressBitWidth  registered RAM address.
- `ram_data_in`  out  dataBitWidth  registered RAM write data.
- `ram_data_out`  in  dataBitWidth  RAM read data (the RAM has a 1-cycle registered read).

## Operation
- Priority register `prio` (0 = A first, 1 = B first). Reset value is 0.
- Arbitration in each cycle:
  - Only one request high: that port is granted.
  - Both requests high: the port selected by `prio` is granted.
  - After any grant, `prio` points to the port that was not granted.
  - No request: `prio` is unchanged.
- At most one of `gnt_a`/`gnt_b` is high. A grant is never given without the matching request.
- Accepted, in-range command: `ram_*` registers load `{we ? write : read, addr, wdata}` at the accept edge.
- Idle cycles: `ram_read_enable` = `ram_write_enable` = 0. `ram_address` and `ram_data_in` hold their last values.
- Out-of-range command (addr ≥ memoryDepth):
  - The command is granted, but both RAM enables stay 0.
  - For a read: at the normal return slot, `rvalid_x` = 1, `rdata_x` = 0 and `err_x` = 1.
  - For a write: `err_x` pulses in the same slot and `rvalid_x` stays 0.
- Return pipeline: a 2-stage shift register of `{valid, port, is_write, err}`. Its stage-2 output drives `rvalid`/`err` and the `rdata` mux.
- `rdata_x` takes `ram_data_out` during its `rvalid_x` pulse. Otherwise it holds its last value.
- Ordering: commands reach the RAM in grant order, so a read after a write to the same address (either port) returns the new data.
- Reset values:
  - `gnt_a`, `gnt_b` = 0 while `rst_n` = 0.
  - All `rvalid`, `err`, and RAM enables = 0.
  - `ram_address`, `ram_data_in`, `rdata_a`, `rdata_b` = 0.
  - The return pipeline is cleared and `prio` = 0.
- Reset mid-operation: in-flight reads are dropped with no `rvalid`. Requesters re-issue after reset.

## Timing
- Cycle N: req_x = 1 and gnt_x = 1; the command is accepted at the end of N.
- Cycle N+1: `ram_*` carries the command; the RAM registers the read/write at the end of N+1.
- Cycle N+2: `rvalid_x` = 1 with `rdata_x` = mem[addr]. Read latency is 2 cycles from the accept edge.
- `err_x` for a write pulses in N+2.
- Throughput is one command per cycle in total:
  - A lone requester holding req high is granted every cycle.
  - With both ports requesting continuously, grants alternate A, B, A, B…
- The combinational path req → gnt must not depend on `ram_data_out`.

## Test plan
- Reset → all outputs 0. Release `rst_n`; with req_a = req_b = 0 for 5 cycles, RAM enables stay 0 and no rvalid occurs.
- Port A writes 0x1234 to addr 5 in cycle N, then reads addr 5 in N+1 → `ram_write_enable` = 1 in N+1; `rvalid_a` = 1 with `rdata_a` = 0x1234 in N+3; `rvalid_b` stays 0.
- Both ports request reads continuously for 6 cycles → gnt order A,B,A,B,A,B. rvalid pulses follow the same order, each 2 cycles after its grant.
- Port B reads addr 27 with memoryDepth = 27 → gnt_b = 1, no RAM enable; 2 cycles later `rvalid_b` = 1, `rdata_b` = 0, `err_b` = 1. Port B writes addr 40 → `err_b` pulses and memory is unchanged.
- A write (A, addr 3, 0xFFFF) and a read (B, addr 3) requested in the same cycle with prio = A → B reads −1 (0xFFFF).
- Two reads are in flight and `rst_n` pulses low for 1 cycle → no rvalid is produced and `prio` = 0. The next simultaneous request is granted to A.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of one single_port_RAM, with registered RAM
// commands, fixed-latency read return and out-of-range address trapping.
module ram_port_arbiter #(
  parameter int unsigned memoryDepth     = 27,
  parameter int unsigned addressBitWidth = 16,
  parameter int unsigned dataBitWidth    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_a,
  input  logic                              we_a,
  input  logic        [addressBitWidth-1:0] addr_a,
  input  logic signed [dataBitWidth-1:0]    wdata_a,
  output logic                              gnt_a,
  output logic                              rvalid_a,
  output logic signed [dataBitWidth-1:0]    rdata_a,
  output logic                              err_a,
  input  logic                              req_b,
  input  logic                              we_b,
  input  logic        [addressBitWidth-1:0] addr_b,
  input  logic signed [dataBitWidth-1:0]    wdata_b,
  output logic                              gnt_b,
  output logic                              rvalid_b,
  output logic signed [dataBitWidth-1:0]    rdata_b,
  output logic                              err_b,
  output logic                              ram_read_enable,
  output logic                              ram_write_enable,
  output logic        [addressBitWidth-1:0] ram_address,
  output logic        [dataBitWidth-1:0]    ram_data_in,
  input  logic        [dataBitWidth-1:0]    ram_data_out
);

  typedef struct packed {
    logic valid;
    logic port;      // 0 = A, 1 = B
    logic is_write;
    logic err;
  } ret_t;

  logic                              prio_q;
  ret_t                              ret1_q, ret2_q;
  logic signed [dataBitWidth-1:0]    rdata_a_q, rdata_b_q;

  logic                              accept;
  logic                              acc_we;
  logic        [addressBitWidth-1:0] acc_addr;
  logic        [dataBitWidth-1:0]    acc_wdata;
  logic                              in_range;

  // Grant depends only on requests, prio and reset, never on RAM data.
  always_comb begin
    gnt_a = rst_n & req_a & (~req_b | ~prio_q);
    gnt_b = rst_n & req_b & (~req_a | prio_q);
  end

  always_comb begin
    accept    = gnt_a | gnt_b;
    acc_we    = gnt_b ? we_b : we_a;
    acc_addr  = gnt_b ? addr_b : addr_a;
    acc_wdata = gnt_b ? wdata_b : wdata_a;
    in_range  = (32'(acc_addr) < memoryDepth);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q           <= 1'b0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ret1_q           <= '0;
      ret2_q           <= '0;
      rdata_a_q        <= '0;
      rdata_b_q        <= '0;
    end else begin
      // After a grant, the other port gets first pick.
      if (accept) prio_q <= gnt_a;
      ram_read_enable  <= accept & ~acc_we & in_range;
      ram_write_enable <= accept & acc_we & in_range;
      if (accept && in_range) begin
        ram_address <= acc_addr;
        ram_data_in <= acc_wdata;
      end
      ret1_q <= '{valid: accept, port: gnt_b, is_write: acc_we, err: ~in_range};
      ret2_q <= ret1_q;
      if (rvalid_a) rdata_a_q <= rdata_a;
      if (rvalid_b) rdata_b_q <= rdata_b;
    end
  end

  always_comb begin
    rvalid_a = ret2_q.valid & ~ret2_q.port & ~ret2_q.is_write;
    rvalid_b = ret2_q.valid &  ret2_q.port & ~ret2_q.is_write;
    err_a    = ret2_q.valid & ~ret2_q.port & ret2_q.err;
    err_b    = ret2_q.valid &  ret2_q.port & ret2_q.err;
    // Trapped reads return zero instead of whatever the RAM output holds.
    rdata_a  = rdata_a_q;
    rdata_b  = rdata_b_q;
    if (rvalid_a) rdata_a = ret2_q.err ? '0 : $signed(ram_data_out);
    if (rvalid_b) rdata_b = ret2_q.err ? '0 : $signed(ram_data_out);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM model.
module tb_ram_port_arbiter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_a, we_a, req_b, we_b;
  logic        [15:0] addr_a, addr_b;
  logic signed [15:0] wdata_a, wdata_b;
  logic               gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
  logic signed [15:0] rdata_a, rdata_b;
  logic               ram_read_enable, ram_write_enable;
  logic        [15:0] ram_address, ram_data_in;
  logic        [15:0] ram_data_out = '0;
  logic        [15:0] mem [0:26];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .memoryDepth    (27),
    .addressBitWidth(16),
    .dataBitWidth   (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_a           (req_a),
    .we_a            (we_a),
    .addr_a          (addr_a),
    .wdata_a         (wdata_a),
    .gnt_a           (gnt_a),
    .rvalid_a        (rvalid_a),
    .rdata_a         (rdata_a),
    .err_a           (err_a),
    .req_b           (req_b),
    .we_b            (we_b),
    .addr_b          (addr_b),
    .wdata_b         (wdata_b),
    .gnt_b           (gnt_b),
    .rvalid_b        (rvalid_b),
    .rdata_b         (rdata_b),
    .err_b           (err_b),
    .ram_read_enable (ram_read_enable),
    .ram_write_enable(ram_write_enable),
    .ram_address     (ram_address),
    .ram_data_in     (ram_data_in),
    .ram_data_out    (ram_data_out)
  );

  // Single-port RAM with 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address[4:0]] <= ram_data_in;
    if (ram_read_enable)  ram_data_out <= mem[ram_address[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 16'd0, 16'h0);
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    repeat (2) next();
    mid();
    check("rst_gnt", {gnt_a, gnt_b}, 0);
    check("rst_valid_err", {rvalid_a, rvalid_b, err_a, err_b}, 0);
    check("rst_ram_en", {ram_read_enable, ram_write_enable}, 0);
    check("rst_ram_addr", ram_address, 0);
    check("rst_ram_din", ram_data_in, 0);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mid();
      check("idle", {ram_read_enable, ram_write_enable, rvalid_a, rvalid_b, gnt_a, gnt_b}, 0);
      next();
    end

    // A writes 0x1234 to addr 5, then reads it back.
    drive_a(1'b1, 1'b1, 16'd5, 16'h1234);
    mid();
    check("wr_gnt", {gnt_a, gnt_b}, 2'b10);
    next();
    drive_a(1'b1, 1'b0, 16'd5, 16'h0);
    mid();
    check("wr_ram_en", {ram_write_enable, ram_read_enable}, 2'b10);
    check("wr_ram_addr", ram_address, 5);
    check("wr_ram_din", ram_data_in, 16'h1234);
    check("rd_gnt", gnt_a, 1);
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    check("rd_ram_en", {ram_write_enable, ram_read_enable}, 2'b01);
    check("wr_no_rvalid", {rvalid_a, rvalid_b, err_a}, 0);
    next();
    mid();
    check("raw_rvalid", {rvalid_a, rvalid_b, err_a}, 3'b100);
    check("raw_rdata", rdata_a, 16'h1234);
    next();

    // Preload addr 1 (A) and addr 2 (B); the last grant to B leaves prio on A.
    drive_a(1'b1, 1'b1, 16'd1, 16'h1111);
    mid();
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    drive_b(1'b1, 1'b1, 16'd2, 16'h2222);
    mid();
    check("pre_gnt_b", {gnt_a, gnt_b}, 2'b01);
    next();
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    next();

    // Both ports read continuously for 6 cycles.
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drive_a(1'b1, 1'b0, 16'd1, 16'h0);
        drive_b(1'b1, 1'b0, 16'd2, 16'h0);
      end else begin
        drive_a(1'b0, 1'b0, 16'd0, 16'h0);
        drive_b(1'b0, 1'b0, 16'd0, 16'h0);
      end
      mid();
      if (k < 6) check($sformatf("rr_gnt%0d", k), {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k >= 2) begin
        check($sformatf("rr_rvalid%0d", k - 2), {rvalid_a, rvalid_b},
              (k % 2 == 0) ? 2'b10 : 2'b01);
        if (k % 2 == 0) check($sformatf("rr_rdata%0d", k - 2), rdata_a, 16'h1111);
        else            check($sformatf("rr_rdata%0d", k - 2), rdata_b, 16'h2222);
      end
      next();
    end

    // Out-of-range read and write from B.
    drive_b(1'b1, 1'b0, 16'd27, 16'h0);
    mid();
    check("oor_rd_gnt", {gnt_a, gnt_b}, 2'b01);
    next();
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    check("oor_rd_en", {ram_read_enable, ram_write_enable}, 0);
    next();
    mid();
    check("oor_rd_ret", {rvalid_b, err_b, rvalid_a, err_a}, 4'b1100);
    check("oor_rd_data", rdata_b, 0);
    next();
    drive_b(1'b1, 1'b1, 16'd40, 16'h7777);
    mid();
    check("oor_wr_gnt", gnt_b, 1);
    next();
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    check("oor_wr_en", {ram_read_enable, ram_write_enable}, 0);
    check("oor_wr_addr_hold", ram_address, 2);
    check("oor_wr_din_hold", ram_data_in, 0);
    next();
    mid();
    check("oor_wr_ret", {err_b, rvalid_b}, 2'b10);
    next();

    // Simultaneous write (A) and read (B) of addr 3 with prio on A.
    drive_a(1'b1, 1'b1, 16'd3, 16'hFFFF);
    drive_b(1'b1, 1'b0, 16'd3, 16'h0);
    mid();
    check("wr_rd_gnt0", {gnt_a, gnt_b}, 2'b10);
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    check("wr_rd_gnt1", {gnt_a, gnt_b}, 2'b01);
    next();
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    mid();
    check("wr_rd_early", rvalid_b, 0);
    next();
    mid();
    check("wr_rd_ret", {rvalid_b, err_b}, 2'b10);
    check("wr_rd_data", {{16{rdata_b[15]}}, rdata_b}, 32'hFFFF_FFFF);
    next();

    // Two A reads in flight, then a 1-cycle reset pulse.
    drive_a(1'b1, 1'b0, 16'd1, 16'h0);
    mid();
    next();
    mid();
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    rst_n = 1'b0;
    mid();
    check("rstmid_rvalid0", {rvalid_a, rvalid_b}, 0);
    next();
    rst_n = 1'b1;
    mid();
    check("rstmid_rvalid1", {rvalid_a, rvalid_b}, 0);
    next();
    mid();
    check("rstmid_rvalid2", {rvalid_a, rvalid_b}, 0);
    check("rstmid_rdata", rdata_a, 0);
    next();
    drive_a(1'b1, 1'b0, 16'd1, 16'h0);
    drive_b(1'b1, 1'b0, 16'd2, 16'h0);
    mid();
    check("rstmid_prio", {gnt_a, gnt_b}, 2'b10);
    next();
    drive_a(1'b0, 1'b0, 16'd0, 16'h0);
    drive_b(1'b0, 1'b0, 16'd0, 16'h0);
    repeat (3) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
